mem_store_checker: RTL and testbench
====================================

Name: mem_store_checker

Overview:
Synthesisable self-checking monitor for the data-memory write bus of the single-cycle MIPS core (memwrite, dataadr, writedata). It generalises the bench's single "address 84 = 7" check to a programmable table of expected stores, checked in order, with strict/lenient modes and a cycle timeout. It reports pass/fail, a failure cause and diagnostics, so benches and FPGA builds share one checker.

Parameters:
WIDTH, 32, width of address and data buses
DEPTH, 8, number of expected-store table entries (≥1)
TIMEOUT, 1024, maximum RUN cycles before failure (≥2)
STRICT, 0, 1 = any store not equal to the current expected entry fails; 0 = stores to other addresses are ignored

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
exp_we  in  1  table write strobe
exp_idx  in  clog2(DEPTH)  table index
exp_addr  in  WIDTH  expected store address
exp_data  in  WIDTH  expected store data
exp_count  in  clog2(DEPTH+1)  number of valid entries, sampled on start
start  in  1  begin checking (single-cycle pulse)
memwrite  in  1  core store enable
dataadr  in  WIDTH  core store address
writedata  in  WIDTH  core store data
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail_cause  out  2  0 none, 1 data mismatch, 2 unexpected address (STRICT), 3 timeout
match_count  out  clog2(DEPTH+1)  entries matched so far
cycle_count  out  clog2(TIMEOUT+1)  RUN cycles elapsed
fail_addr  out  WIDTH  dataadr of the failing store (0 for timeout)
fail_data  out  WIDTH  writedata of the failing store (0 for timeout)

Behaviour:
- Reset: state IDLE; busy, done and pass are 0; fail_cause, match_count, cycle_count, fail_addr and fail_data are 0. The table is not cleared; it retains its contents across reset.
- Table write: when exp_we=1 and the state is not RUN, entry[exp_idx] <= {exp_addr, exp_data} at the clock edge. exp_we during RUN is ignored. exp_idx ≥ DEPTH is ignored.
- States: IDLE, RUN, PASS, FAIL.
- IDLE, PASS or FAIL with start=1:
  - Latch exp_count, saturated to DEPTH.
  - Clear ptr, match_count, cycle_count, fail_* and pass.
  - If the latched count is 0, go to PASS; otherwise go to RUN.
- start while in RUN is ignored.
- RUN, once per cycle:
  - cycle_count increments, saturating at TIMEOUT.
  - If memwrite=1 and dataadr == entry[ptr].addr:
    - If writedata == entry[ptr].data: ptr and match_count increment. If this was the last entry (match_count reaches the latched count), go to PASS.
    - Otherwise go to FAIL with cause 1 and capture dataadr and writedata.
  - If memwrite=1 and the address differs: with STRICT=1, go to FAIL with cause 2 and capture; with STRICT=0, ignore the store.
  - memwrite=0 is a no-op.
  - Timeout: if cycle_count == TIMEOUT-1 and no transition out of RUN occurs this cycle, go to FAIL with cause 3.
  - Priority within one cycle: final match (PASS) > mismatch/unexpected (FAIL 1/2) > timeout (FAIL 3).
- Outputs are registered. busy, done and pass reflect the state one cycle after the deciding edge. Latency from the final matching store to pass=1 is exactly 1 cycle.
- PASS and FAIL are sticky until start or reset. The bus is ignored in these states.
- Reset mid-RUN aborts the run: state goes to IDLE and all outputs return to their reset values.
- Matching is exact WIDTH-bit equality. X/Z inputs are not handled specially.

Test Plan:
1. Single entry {84, 7}, count=1, start; store (80, 3) then (84, 7) with STRICT=0 -> first store ignored; pass=1, done=1 one cycle after the (84, 7) edge; match_count=1; fail_cause=0.
2. Same table; store (84, -5) -> FAIL, fail_cause=1, fail_addr=84, fail_data=0xFFFFFFFB, match_count=0.
3. STRICT=1, table {84, 7}; store (80, 3) -> FAIL, fail_cause=2, fail_addr=80, fail_data=3.
4. Table {(0, 1), (4, 2), (8, 3)}, count=3, TIMEOUT=16; stores in order with idle cycles between -> match_count steps 1, 2, 3; pass=1. Repeat with only the first two stores -> FAIL, fail_cause=3, cycle_count=16, match_count=2, fail_addr=0.
5. TIMEOUT=16; final matching store arrives on the cycle where cycle_count==15 -> PASS, not timeout. count=0 on start -> PASS next cycle with match_count=0.
6. Assert reset mid-RUN after one match -> IDLE, all outputs 0; restart with start and the same table -> table contents retained, run passes. exp_we during RUN leaves the table unchanged.

Source files
------------

// File: rtl/mem_store_checker_if.sv
// Data-memory write bus of the single-cycle MIPS core, as observed by mem_store_checker.
// The core (or a bench) drives it as master; the checker only listens.
interface mem_store_checker_if #(
  parameter int WIDTH = 32
);
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/mem_store_checker.sv
// Self-checking monitor for the core's store bus: compares stores, in order, against a
// programmable table of expected (address, data) pairs, with strict/lenient modes and a timeout.
module mem_store_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int STRICT  = 0,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IW-1:0]     exp_idx,
  input  logic [WIDTH-1:0]  exp_addr,
  input  logic [WIDTH-1:0]  exp_data,
  input  logic [CW-1:0]     exp_count,
  input  logic              start,
  mem_store_checker_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_cause,
  output logic [CW-1:0]     match_count,
  output logic [TW-1:0]     cycle_count,
  output logic [WIDTH-1:0]  fail_addr,
  output logic [WIDTH-1:0]  fail_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_DATA     = 2'd1;
  localparam logic [1:0] CAUSE_UNEXP    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [IW-1:0]    ptr_r;
  logic [WIDTH-1:0] tab_addr_r [DEPTH];
  logic [WIDTH-1:0] tab_data_r [DEPTH];

  logic             idx_ok_s;
  logic [CW-1:0]    start_count_s;
  logic [WIDTH-1:0] cur_addr_s;
  logic [WIDTH-1:0] cur_data_s;
  logic             addr_eq_s;
  logic             match_s;
  logic             final_s;
  logic             miss_s;
  logic             unexp_s;
  logic             timeout_s;
  logic [TW-1:0]    cycle_next_s;

  assign idx_ok_s      = (32'(exp_idx) < 32'(DEPTH));
  assign start_count_s = (32'(exp_count) > 32'(DEPTH)) ? CW'(DEPTH) : exp_count;

  // ptr_r stays below the latched count while running, so the lookup is always in range.
  assign cur_addr_s    = tab_addr_r[ptr_r];
  assign cur_data_s    = tab_data_r[ptr_r];
  assign addr_eq_s     = (bus.dataadr == cur_addr_s);
  assign match_s       = bus.memwrite && addr_eq_s && (bus.writedata == cur_data_s);
  assign final_s       = match_s && ((match_count + CW'(1)) == count_r);
  assign miss_s        = bus.memwrite && addr_eq_s && (bus.writedata != cur_data_s);
  assign unexp_s       = bus.memwrite && !addr_eq_s && (STRICT != 0);
  assign timeout_s     = (cycle_count == TW'(TIMEOUT - 1));
  assign cycle_next_s  = (cycle_count == TW'(TIMEOUT)) ? cycle_count : cycle_count + TW'(1);

  // Expected-store table: deliberately not reset so a program survives an aborted run.
  always_ff @(posedge clk) begin
    if (exp_we && (state_r != ST_RUN) && idx_ok_s) begin
      tab_addr_r[exp_idx] <= exp_addr;
      tab_data_r[exp_idx] <= exp_data;
    end
  end

  // Checker FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      count_r     <= {CW{1'b0}};
      ptr_r       <= {IW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_cause  <= CAUSE_NONE;
      match_count <= {CW{1'b0}};
      cycle_count <= {TW{1'b0}};
      fail_addr   <= {WIDTH{1'b0}};
      fail_data   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            count_r     <= start_count_s;
            ptr_r       <= {IW{1'b0}};
            match_count <= {CW{1'b0}};
            cycle_count <= {TW{1'b0}};
            fail_cause  <= CAUSE_NONE;
            fail_addr   <= {WIDTH{1'b0}};
            fail_data   <= {WIDTH{1'b0}};
            if (start_count_s == {CW{1'b0}}) begin
              state_r <= ST_PASS;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_next_s;
          if (match_s) begin
            ptr_r       <= ptr_r + IW'(1);
            match_count <= match_count + CW'(1);
          end
          // Final match beats a bad store, which beats the timeout.
          if (final_s) begin
            state_r <= ST_PASS;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
          end else if (miss_s || unexp_s) begin
            state_r    <= ST_FAIL;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            fail_cause <= miss_s ? CAUSE_DATA : CAUSE_UNEXP;
            fail_addr  <= bus.dataadr;
            fail_data  <= bus.writedata;
          end else if (timeout_s) begin
            state_r    <= ST_FAIL;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            fail_cause <= CAUSE_TIMEOUT;
            fail_addr  <= {WIDTH{1'b0}};
            fail_data  <= {WIDTH{1'b0}};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_checker.sv
// Bench for mem_store_checker: a lenient and a strict instance share one store bus and are
// checked against directed expectations and a behavioural model under random stimulus.
module tb_mem_store_checker;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         exp_we = 1'b0;
  logic [2:0]   exp_idx = 3'd0;
  logic [W-1:0] exp_addr = 32'd0;
  logic [W-1:0] exp_data = 32'd0;
  logic [3:0]   exp_count = 4'd0;
  logic         start = 1'b0;

  logic         busy_v [2];
  logic         done_v [2];
  logic         pass_v [2];
  logic [1:0]   cause_v [2];
  logic [3:0]   mc_v [2];
  logic [4:0]   cc_v [2];
  logic [W-1:0] fa_v [2];
  logic [W-1:0] fd_v [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: 0 idle, 1 running, 2 passed, 3 failed; index 0 lenient, 1 strict.
  int           m_st [2];
  int           m_cnt [2];
  int           m_mc [2];
  int           m_cc [2];
  int           m_cause [2];
  logic [W-1:0] m_fa [2];
  logic [W-1:0] m_fd [2];
  logic [W-1:0] m_ta [2][D];
  logic [W-1:0] m_td [2][D];

  mem_store_checker_if #(.WIDTH(W)) bus ();

  mem_store_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .STRICT(0)) dut_lenient (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_count(exp_count), .start(start), .bus(bus),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_cause(cause_v[0]),
    .match_count(mc_v[0]), .cycle_count(cc_v[0]), .fail_addr(fa_v[0]), .fail_data(fd_v[0])
  );

  mem_store_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .STRICT(1)) dut_strict (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_count(exp_count), .start(start), .bus(bus),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_cause(cause_v[1]),
    .match_count(mc_v[1]), .cycle_count(cc_v[1]), .fail_addr(fa_v[1]), .fail_data(fd_v[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [77:0] mk(input logic b, input logic d, input logic p,
                                     input int c, input int mc, input int cc,
                                     input logic [W-1:0] fa, input logic [W-1:0] fd);
    return {b, d, p, 2'(c), 4'(mc), 5'(cc), fa, fd};
  endfunction

  function automatic logic [77:0] stat_of(input int s);
    return {busy_v[s], done_v[s], pass_v[s], cause_v[s], mc_v[s], cc_v[s], fa_v[s], fd_v[s]};
  endfunction

  function automatic logic [77:0] model_of(input int s);
    return mk(m_st[s] == 1, m_st[s] >= 2, m_st[s] == 2, m_cause[s], m_mc[s], m_cc[s],
              m_fa[s], m_fd[s]);
  endfunction

  // Advances the reference by one clock using the inputs about to be sampled.
  task automatic model_step();
    int old_cc;
    for (int s = 0; s < 2; s++) begin
      if (exp_we && m_st[s] != 1) begin
        m_ta[s][exp_idx] = exp_addr;
        m_td[s][exp_idx] = exp_data;
      end
      if (reset) begin
        m_st[s] = 0; m_cnt[s] = 0; m_mc[s] = 0; m_cc[s] = 0; m_cause[s] = 0;
        m_fa[s] = 32'd0; m_fd[s] = 32'd0;
      end else if (m_st[s] != 1) begin
        if (start) begin
          m_cnt[s] = (int'(exp_count) > D) ? D : int'(exp_count);
          m_mc[s] = 0; m_cc[s] = 0; m_cause[s] = 0; m_fa[s] = 32'd0; m_fd[s] = 32'd0;
          m_st[s] = (m_cnt[s] == 0) ? 2 : 1;
        end
      end else begin
        old_cc = m_cc[s];
        if (m_cc[s] < TO) m_cc[s]++;
        if (bus.memwrite) begin
          if (bus.dataadr == m_ta[s][m_mc[s]]) begin
            if (bus.writedata == m_td[s][m_mc[s]]) begin
              m_mc[s]++;
              if (m_mc[s] == m_cnt[s]) m_st[s] = 2;
            end else begin
              m_st[s] = 3; m_cause[s] = 1; m_fa[s] = bus.dataadr; m_fd[s] = bus.writedata;
            end
          end else if (s == 1) begin
            m_st[s] = 3; m_cause[s] = 2; m_fa[s] = bus.dataadr; m_fd[s] = bus.writedata;
          end
        end
        if (m_st[s] == 1 && old_cc == TO - 1) begin
          m_st[s] = 3; m_cause[s] = 3; m_fa[s] = 32'd0; m_fd[s] = 32'd0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
    exp_we = 1'b1; exp_idx = 3'(idx); exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input int cnt);
    exp_count = 4'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
    bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
    tick();
    bus.memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    logic [77:0] e;
    reset = 1'b1;
    idle(2);
    e = mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < D; i++) wr(i, 32'h100 + 32'(i), 32'(i));
    n_checks++;
    if (stat_of(0) !== e) begin
      n_fail++; $display("FAIL idle_after_table_write: got %h expected %h", stat_of(0), e);
    end
  endtask

  task automatic test_single();
    logic [77:0] e;
    wr(0, 32'd84, 32'd7);
    go(1);
    e = mk(1'b1, 1'b0, 1'b0, 0, 0, 0, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL single_running dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
    store(32'd80, 32'd3);
    e = mk(1'b1, 1'b0, 1'b0, 0, 0, 1, 32'd0, 32'd0);
    n_checks++;
    if (stat_of(0) !== e) begin
      n_fail++; $display("FAIL lenient_ignore_other: got %h expected %h", stat_of(0), e);
    end
    e = mk(1'b0, 1'b1, 1'b0, 2, 0, 1, 32'd80, 32'd3);
    n_checks++;
    if (stat_of(1) !== e) begin
      n_fail++; $display("FAIL strict_unexpected: got %h expected %h", stat_of(1), e);
    end
    store(32'd84, 32'd7);
    e = mk(1'b0, 1'b1, 1'b1, 0, 1, 2, 32'd0, 32'd0);
    n_checks++;
    if (stat_of(0) !== e) begin
      n_fail++; $display("FAIL lenient_pass: got %h expected %h", stat_of(0), e);
    end
    e = mk(1'b0, 1'b1, 1'b0, 2, 0, 1, 32'd80, 32'd3);
    n_checks++;
    if (stat_of(1) !== e) begin
      n_fail++; $display("FAIL strict_fail_sticky: got %h expected %h", stat_of(1), e);
    end
  endtask

  task automatic test_mismatch();
    logic [77:0] e;
    go(1);
    store(32'd84, 32'hFFFF_FFFB);
    e = mk(1'b0, 1'b1, 1'b0, 1, 0, 1, 32'd84, 32'hFFFF_FFFB);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL data_mismatch dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
  endtask

  task automatic test_sequence_timeout();
    logic [77:0] e [3];
    int n;
    wr(0, 32'd0, 32'd1); wr(1, 32'd4, 32'd2); wr(2, 32'd8, 32'd3);
    go(3);
    store(32'd0, 32'd1); e[0] = stat_of(0) ^ stat_of(1);
    idle(2);
    store(32'd4, 32'd2); e[1] = stat_of(0) ^ stat_of(1);
    idle(2);
    store(32'd8, 32'd3);
    e[2] = mk(1'b0, 1'b1, 1'b1, 0, 3, 7, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e[2]) begin
        n_fail++; $display("FAIL sequence_pass dut%0d: got %h expected %h", s, stat_of(s), e[2]);
      end
    end
    n_checks++;
    if (e[0] !== 78'd0 || e[1] !== 78'd0) begin
      n_fail++; $display("FAIL sequence_agree: got diff %h %h expected 0", e[0], e[1]);
    end
    go(3);
    store(32'd0, 32'd1);
    e[0] = mk(1'b1, 1'b0, 1'b0, 0, 1, 1, 32'd0, 32'd0);
    n_checks++;
    if (stat_of(0) !== e[0]) begin
      n_fail++; $display("FAIL step_match1: got %h expected %h", stat_of(0), e[0]);
    end
    idle(1);
    store(32'd4, 32'd2);
    e[0] = mk(1'b1, 1'b0, 1'b0, 0, 2, 3, 32'd0, 32'd0);
    n_checks++;
    if (stat_of(0) !== e[0]) begin
      n_fail++; $display("FAIL step_match2: got %h expected %h", stat_of(0), e[0]);
    end
    n = 0;
    for (int i = 0; i < 40 && !done_v[0]; i++) begin
      tick(); n++;
    end
    n_checks++;
    if (n !== 13) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 13", n);
    end
    e[0] = mk(1'b0, 1'b1, 1'b0, 3, 2, 16, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e[0]) begin
        n_fail++; $display("FAIL timeout dut%0d: got %h expected %h", s, stat_of(s), e[0]);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    logic [77:0] e;
    go(1);
    idle(15);
    e = mk(1'b1, 1'b0, 1'b0, 0, 0, 15, 32'd0, 32'd0);
    n_checks++;
    if (stat_of(0) !== e) begin
      n_fail++; $display("FAIL before_timeout: got %h expected %h", stat_of(0), e);
    end
    store(32'd0, 32'd1);
    e = mk(1'b0, 1'b1, 1'b1, 0, 1, 16, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL last_cycle_pass dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
    go(1);
    idle(15);
    store(32'd100, 32'd5);
    e = mk(1'b0, 1'b1, 1'b0, 3, 0, 16, 32'd0, 32'd0);
    n_checks++;
    if (stat_of(0) !== e) begin
      n_fail++; $display("FAIL lenient_timeout_stray: got %h expected %h", stat_of(0), e);
    end
    e = mk(1'b0, 1'b1, 1'b0, 2, 0, 16, 32'd100, 32'd5);
    n_checks++;
    if (stat_of(1) !== e) begin
      n_fail++; $display("FAIL strict_over_timeout: got %h expected %h", stat_of(1), e);
    end
    go(0);
    e = mk(1'b0, 1'b1, 1'b1, 0, 0, 0, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL zero_count dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [77:0] e;
    go(3);
    store(32'd0, 32'd1);
    wr(1, 32'd4, 32'd99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL abort_reset dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
    go(3);
    store(32'd0, 32'd1); store(32'd4, 32'd2); store(32'd8, 32'd3);
    e = mk(1'b0, 1'b1, 1'b1, 0, 3, 3, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stat_of(s) !== e) begin
        n_fail++; $display("FAIL table_retained dut%0d: got %h expected %h", s, stat_of(s), e);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < D; i++) wr(i, 32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 3)));
      go($urandom_range(0, 10));
      for (int c = 0; c < 20; c++) begin
        r = $urandom_range(0, 9);
        bus.memwrite = (r < 6);
        if (r < 4 && m_st[0] == 1) begin
          bus.dataadr = m_ta[0][m_mc[0]];
          bus.writedata = (r == 0) ? 32'($urandom_range(0, 3)) : m_td[0][m_mc[0]];
        end else begin
          bus.dataadr = 32'($urandom_range(0, 4) * 4);
          bus.writedata = 32'($urandom_range(0, 3));
        end
        start = ($urandom_range(0, 15) == 0);
        exp_count = 4'($urandom_range(0, 10));
        exp_we = ($urandom_range(0, 9) == 0);
        exp_idx = 3'($urandom_range(0, 7));
        exp_addr = 32'($urandom_range(0, 3) * 4);
        exp_data = 32'($urandom_range(0, 3));
        reset = ($urandom_range(0, 49) == 0);
        tick();
        for (int s = 0; s < 2; s++) begin
          n_checks++;
          if (stat_of(s) !== model_of(s)) begin
            n_fail++;
            $display("FAIL random it%0d c%0d dut%0d: got %h expected %h", it, c, s,
                     stat_of(s), model_of(s));
          end
        end
      end
      bus.memwrite = 1'b0; start = 1'b0; exp_we = 1'b0; reset = 1'b0;
      tick();
    end
  endtask

  initial begin
    bus.memwrite = 1'b0;
    bus.dataadr = 32'd0;
    bus.writedata = 32'd0;
    test_reset();
    test_single();
    test_mismatch();
    test_sequence_timeout();
    test_timeout_boundary();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
